cfi_commit_monitor: RTL and testbench
=====================================

CFI_COMMIT_MONITOR -- requirements
Module: cfi_commit_monitor

Interface
REQ-001 Parameter NR_COMMIT_PORTS, default 2: number of commit slots inspected per cycle, legal range 1..4.
REQ-002 Parameter NOP_OP, default ariane_pkg::ADD: opcode of the marker instruction.
REQ-003 Parameter NOP_RD, default 5'h0: destination register of the marker.
REQ-004 Parameter NOP_RS1, default 5'h0: source register of the marker.
REQ-005 Parameter IMM_RET, default 5'h1: immediate (result[4:0]) of the return marker.
REQ-006 Parameter IMM_CALL, default 5'h2: immediate (result[4:0]) of the call marker.
REQ-007 Parameter CNT_WIDTH, default 16: width of the violation counter.
REQ-008 clk_i  in  1  single clock, all flops on its rising edge.
REQ-009 rst_ni  in  1  asynchronous active-low reset.
REQ-010 flush_i  in  1  pipeline flush, abandons pending marker check.
REQ-011 csr_en_i  in  1  checker enable.
REQ-012 enforce_i  in  1  1 = violations raise exception_o; 0 = log-only.
REQ-013 commit_ack_i  in  NR_COMMIT_PORTS  per-slot commit acknowledge, contiguous from slot 0.
REQ-014 commit_instr_i  in  NR_COMMIT_PORTS x scoreboard_entry_t  instructions at commit.
REQ-015 exception_o  out  exception_t  CFI breakpoint exception to commit stage.
REQ-016 cfi_signal_o  out  1  one-cycle pulse per violating cycle, independent of enforce_i.
REQ-017 viol_count_o  out  CNT_WIDTH  saturating count of violations.
REQ-018 last_viol_pc_o  out  64  PC of the most recent reported violating instruction.
REQ-019 pending_o  out  2  00 none, 01 awaiting return marker, 10 awaiting call marker.

Function
REQ-020 Slot k is "retired" when commit_ack_i[k]=1 and commit_instr_i[k].ex.valid=0; each retired slot is a distinct instruction (no previous-entry comparison).
REQ-021 Return: op==JALR, rd==0, rs1==1; call: op in {JAL,JALR}, rd!=0; marker-ret/marker-call: op==NOP_OP, rd==NOP_RD, rs1==NOP_RS1, result[4:0]==IMM_RET/IMM_CALL.
REQ-022 Slots SHALL be evaluated in order 0..NR_COMMIT_PORTS-1 within one cycle, pending state passed combinationally slot to slot, final value registered.
REQ-023 For a retired slot with pending!=00: matching marker clears pending; any other instruction is a violation and clears pending.
REQ-024 After the step in REQ-023, a retired call sets pending=10 and a retired return sets pending=01 (a violating call/return re-arms pending).
REQ-025 An acked slot with ex.valid=1 SHALL clear pending without a violation; later slots that cycle are evaluated from pending=00.
REQ-026 Unacked slots SHALL not change pending; pending persists across idle cycles indefinitely.
REQ-027 flush_i=1 SHALL clear pending at the next edge and suppress all violations that cycle.
REQ-028 csr_en_i=0 SHALL suppress detection, hold pending at 00 and leave counter and outputs unchanged except clearing exception_o.valid.
REQ-029 Violation latency: exception_o, cfi_signal_o, viol_count_o, last_viol_pc_o update at the edge following the violating commit cycle (1 cycle).
REQ-030 exception_o.valid=enforce_i for exactly one cycle per violating cycle; cause=riscv::BREAKPOINT, tval=PC of the lowest-numbered violating slot.
REQ-031 Multiple violations in one cycle: counter adds their number, saturating at all-ones; last_viol_pc_o takes the lowest-numbered violating slot.
REQ-032 In non-violating cycles exception_o.valid=0, cause=0, tval=0, cfi_signal_o=0.

Reset
REQ-033 On rst_ni=0, immediately and independent of clk_i: pending=00, exception_o all zero, cfi_signal_o=0, viol_count_o=0, last_viol_pc_o=0.
REQ-034 Reset asserted mid-check SHALL discard pending; first commit after release is evaluated from pending=00.

Verification
REQ-035 Slot0 JALR rd=0 rs1=1, slot1 ADD x0,x0,1 same cycle -> no exception, pending 00, count 0.
REQ-036 Slot1 JAL rd=1 pc=0x8000_0010; next cycle slot0 ADD x0,x0,5 pc=0x8000_0014, enforce_i=1 -> next edge exception_o.valid=1, cause BREAKPOINT, tval=0x8000_0014, count 1.
REQ-037 Call retired, 3 idle cycles with acks low, then slot0 call marker -> no violation; pending 10 throughout idle.
REQ-038 enforce_i=0, two slots each violating a pending check in one cycle (NR_COMMIT_PORTS=4) -> exception_o.valid=0, cfi_signal_o=1, count +2.
REQ-039 Return retired, then flush_i=1 with non-marker on slot0 -> no violation, pending 00.
REQ-040 viol_count_o preloaded to all-ones by forced violations with CNT_WIDTH=4 -> 16th violation keeps 4'hF; async reset mid-cycle -> all outputs zero before next edge.

Source files
------------

// File: rtl/cfi_commit_monitor_if.sv
// Minimal stand-ins for the core's riscv/ariane_pkg types, plus the commit-port bundle
// that the CFI commit monitor observes.
package riscv;
   localparam logic [63:0] BREAKPOINT = 64'd3;
endpackage

package ariane_pkg;
   typedef enum logic [3:0] {ADD, SUB, ANDL, ORL, XORL, JAL, JALR, LOAD, STORE} fu_op;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [63:0] pc;
      fu_op        op;
      logic [4:0]  rs1;
      logic [4:0]  rd;
      logic [63:0] result;
      exception_t  ex;
   } scoreboard_entry_t;
endpackage

interface cfi_commit_monitor_if #(
   parameter int unsigned NR_COMMIT_PORTS = 2
) ();
   logic [NR_COMMIT_PORTS-1:0]                          commit_ack;
   ariane_pkg::scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr;

   modport master (output commit_ack, output commit_instr);
   modport slave  (input  commit_ack, input  commit_instr);
endinterface

// File: rtl/cfi_commit_monitor.sv
// Shadow-stack-free CFI check: every retired call/return must be followed by its marker
// instruction; anything else is counted, logged and optionally raised as a breakpoint.
module cfi_commit_monitor #(
   parameter int unsigned       NR_COMMIT_PORTS = 2,
   parameter ariane_pkg::fu_op  NOP_OP          = ariane_pkg::ADD,
   parameter logic [4:0]        NOP_RD          = 5'h0,
   parameter logic [4:0]        NOP_RS1         = 5'h0,
   parameter logic [4:0]        IMM_RET         = 5'h1,
   parameter logic [4:0]        IMM_CALL        = 5'h2,
   parameter int unsigned       CNT_WIDTH       = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    flush_i,
   input  logic                    csr_en_i,
   input  logic                    enforce_i,
   cfi_commit_monitor_if.slave     commit_if,
   output ariane_pkg::exception_t  exception_o,
   output logic                    cfi_signal_o,
   output logic [CNT_WIDTH-1:0]    viol_count_o,
   output logic [63:0]             last_viol_pc_o,
   output logic [1:0]              pending_o
);
   import ariane_pkg::*;

   typedef enum logic [1:0] {
      PEND_NONE = 2'b00,
      PEND_RET  = 2'b01,
      PEND_CALL = 2'b10
   } pendState_e;

   pendState_e              pending_q, pending_d;
   exception_t              exception_q;
   logic                    cfiSignal_q;
   logic [CNT_WIDTH-1:0]    violCount_q, violCount_d;
   logic [63:0]             lastViolPc_q;

   logic [NR_COMMIT_PORTS-1:0] isRet, isCall, isMarkRet, isMarkCall;
   logic [2:0]                 violCnt;
   logic                       violFound;
   logic [63:0]                violPc;
   logic [CNT_WIDTH+2:0]       countSum;

   // Per-slot decode of control-flow instructions and the two marker encodings.
   always_comb begin
      isRet      = '0;
      isCall     = '0;
      isMarkRet  = '0;
      isMarkCall = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         isRet[k]      = (commit_if.commit_instr[k].op == JALR) &&
                         (commit_if.commit_instr[k].rd == 5'd0) &&
                         (commit_if.commit_instr[k].rs1 == 5'd1);
         isCall[k]     = ((commit_if.commit_instr[k].op == JAL) ||
                          (commit_if.commit_instr[k].op == JALR)) &&
                         (commit_if.commit_instr[k].rd != 5'd0);
         isMarkRet[k]  = (commit_if.commit_instr[k].op == NOP_OP) &&
                         (commit_if.commit_instr[k].rd == NOP_RD) &&
                         (commit_if.commit_instr[k].rs1 == NOP_RS1) &&
                         (commit_if.commit_instr[k].result[4:0] == IMM_RET);
         isMarkCall[k] = (commit_if.commit_instr[k].op == NOP_OP) &&
                         (commit_if.commit_instr[k].rd == NOP_RD) &&
                         (commit_if.commit_instr[k].rs1 == NOP_RS1) &&
                         (commit_if.commit_instr[k].result[4:0] == IMM_CALL);
      end
   end

   // Pending state ripples through the slots in program order; the first offender's PC
   // is kept for tval/last_viol_pc. Excepting slots only drop the pending check.
   always_comb begin
      pending_d = pending_q;
      violCnt   = '0;
      violFound = 1'b0;
      violPc    = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         if (commit_if.commit_ack[k]) begin
            if (commit_if.commit_instr[k].ex.valid) begin
               pending_d = PEND_NONE;
            end else begin
               if (pending_d != PEND_NONE) begin
                  if (!((pending_d == PEND_RET && isMarkRet[k]) ||
                        (pending_d == PEND_CALL && isMarkCall[k]))) begin
                     violCnt = violCnt + 3'd1;
                     if (!violFound) begin
                        violFound = 1'b1;
                        violPc    = commit_if.commit_instr[k].pc;
                     end
                  end
                  pending_d = PEND_NONE;
               end
               if (isCall[k]) begin
                  pending_d = PEND_CALL;
               end else if (isRet[k]) begin
                  pending_d = PEND_RET;
               end
            end
         end
      end
      countSum    = {3'b000, violCount_q} + {{CNT_WIDTH{1'b0}}, violCnt};
      violCount_d = (|countSum[CNT_WIDTH+2:CNT_WIDTH]) ? {CNT_WIDTH{1'b1}}
                                                        : countSum[CNT_WIDTH-1:0];
   end

   // Disabled keeps the log but drops any pending check; a flush abandons the check
   // and masks whatever the flushed slots would have reported.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q    <= PEND_NONE;
         exception_q  <= '0;
         cfiSignal_q  <= 1'b0;
         violCount_q  <= '0;
         lastViolPc_q <= '0;
      end else if (!csr_en_i) begin
         pending_q         <= PEND_NONE;
         exception_q.valid <= 1'b0;
         cfiSignal_q       <= 1'b0;
      end else if (flush_i || (violCnt == 3'd0)) begin
         pending_q   <= flush_i ? PEND_NONE : pending_d;
         exception_q <= '0;
         cfiSignal_q <= 1'b0;
      end else begin
         pending_q         <= pending_d;
         exception_q.cause <= riscv::BREAKPOINT;
         exception_q.tval  <= violPc;
         exception_q.valid <= enforce_i;
         cfiSignal_q       <= 1'b1;
         violCount_q       <= violCount_d;
         lastViolPc_q      <= violPc;
      end
   end

   assign exception_o    = exception_q;
   assign cfi_signal_o   = cfiSignal_q;
   assign viol_count_o   = violCount_q;
   assign last_viol_pc_o = lastViolPc_q;
   assign pending_o      = pending_q;

endmodule

// File: tb/tb_cfi_commit_monitor.sv
// Scoreboard bench for cfi_commit_monitor (4 commit ports, 4-bit counter): a reference
// model predicts each cycle's registered outputs, which are compared one cycle later.
module tb_cfi_commit_monitor;
   import ariane_pkg::*;

   localparam int NP = 4;
   localparam int CW = 4;

   typedef struct {
      logic        valid;
      logic [63:0] cause;
      logic [63:0] tval;
      logic        cfi;
      logic [3:0]  cnt;
      logic [63:0] pc;
      logic [1:0]  pend;
   } expect_t;

   logic clk;
   logic rstN;
   logic flush, csrEn, enforce;
   exception_t excOut;
   logic cfiSig;
   logic [CW-1:0] violCount;
   logic [63:0] lastPc;
   logic [1:0] pending;

   cfi_commit_monitor_if #(.NR_COMMIT_PORTS(NP)) commitBus ();

   cfi_commit_monitor #(.NR_COMMIT_PORTS(NP), .CNT_WIDTH(CW)) dut (
      .clk_i          (clk),
      .rst_ni         (rstN),
      .flush_i        (flush),
      .csr_en_i       (csrEn),
      .enforce_i      (enforce),
      .commit_if      (commitBus.slave),
      .exception_o    (excOut),
      .cfi_signal_o   (cfiSig),
      .viol_count_o   (violCount),
      .last_viol_pc_o (lastPc),
      .pending_o      (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   expect_t sbQ[$];

   logic [1:0]  mPend;
   logic [3:0]  mCount;
   logic [63:0] mLastPc, mCause, mTval;
   logic        mValid, mCfi;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic scoreboard_entry_t mkInstr(fu_op op, logic [4:0] rd, logic [4:0] rs1,
                                                 logic [4:0] imm, logic [63:0] pc, logic exv);
      scoreboard_entry_t e;
      e.pc       = pc;
      e.op       = op;
      e.rs1      = rs1;
      e.rd       = rd;
      e.result   = {59'd0, imm};
      e.ex.cause = 64'd0;
      e.ex.tval  = 64'd0;
      e.ex.valid = exv;
      return e;
   endfunction

   // 0 other, 1 return, 2 call, 3 return marker, 4 call marker
   function automatic int classify(scoreboard_entry_t e);
      if (e.op == JALR && e.rd == 5'd0 && e.rs1 == 5'd1) return 1;
      if ((e.op == JAL || e.op == JALR) && e.rd != 5'd0) return 2;
      if (e.op == ADD && e.rd == 5'd0 && e.rs1 == 5'd0 && e.result[4:0] == 5'd1) return 3;
      if (e.op == ADD && e.rd == 5'd0 && e.rs1 == 5'd0 && e.result[4:0] == 5'd2) return 4;
      return 0;
   endfunction

   task automatic modelReset();
      mPend = 2'b00; mCount = 4'd0; mLastPc = 64'd0;
      mCause = 64'd0; mTval = 64'd0; mValid = 1'b0; mCfi = 1'b0;
   endtask

   task automatic modelStep(input logic fl, input logic en, input logic enf,
                            input logic [3:0] ack, input scoreboard_entry_t s[4]);
      logic [1:0] p;
      int n;
      int kind;
      logic [63:0] firstPc;
      if (!en) begin
         mPend = 2'b00; mValid = 1'b0; mCfi = 1'b0;
         return;
      end
      p = mPend; n = 0; firstPc = 64'd0;
      for (int k = 0; k < 4; k++) begin
         if (ack[k]) begin
            if (s[k].ex.valid) begin
               p = 2'b00;
            end else begin
               kind = classify(s[k]);
               if (p != 2'b00) begin
                  if (!((p == 2'b01 && kind == 3) || (p == 2'b10 && kind == 4))) begin
                     if (n == 0) firstPc = s[k].pc;
                     n++;
                  end
                  p = 2'b00;
               end
               if (kind == 2) p = 2'b10;
               else if (kind == 1) p = 2'b01;
            end
         end
      end
      if (fl) begin
         n = 0; p = 2'b00;
      end
      mPend = p;
      if (n > 0) begin
         mValid = enf; mCause = 64'd3; mTval = firstPc; mCfi = 1'b1;
         mCount = (int'(mCount) + n > 15) ? 4'hF : 4'(int'(mCount) + n);
         mLastPc = firstPc;
      end else begin
         mValid = 1'b0; mCause = 64'd0; mTval = 64'd0; mCfi = 1'b0;
      end
   endtask

   task automatic compareEntry();
      expect_t e;
      if (sbQ.size() == 0) begin
         checkOutput("sbQueueEmpty", 64'd0, 64'd1);
         return;
      end
      e = sbQ.pop_front();
      checkOutput("excValid", {63'd0, excOut.valid}, {63'd0, e.valid});
      checkOutput("excCause", excOut.cause, e.cause);
      checkOutput("excTval",  excOut.tval,  e.tval);
      checkOutput("cfiSignal", {63'd0, cfiSig}, {63'd0, e.cfi});
      checkOutput("violCount", {60'd0, violCount}, {60'd0, e.cnt});
      checkOutput("lastViolPc", lastPc, e.pc);
      checkOutput("pending", {62'd0, pending}, {62'd0, e.pend});
   endtask

   // Called at posedge+1: drive one commit cycle, predict, then compare after the edge.
   task automatic applyStimulus(input logic fl, input logic en, input logic enf, input logic [3:0] ack,
                                input scoreboard_entry_t s0, input scoreboard_entry_t s1,
                                input scoreboard_entry_t s2, input scoreboard_entry_t s3);
      scoreboard_entry_t s[4];
      expect_t e;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      flush = fl; csrEn = en; enforce = enf;
      commitBus.commit_ack = ack;
      for (int k = 0; k < 4; k++) commitBus.commit_instr[k] = s[k];
      modelStep(fl, en, enf, ack, s);
      e.valid = mValid; e.cause = mCause; e.tval = mTval; e.cfi = mCfi;
      e.cnt = mCount; e.pc = mLastPc; e.pend = mPend;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      compareEntry();
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0000, mkInstr(SUB, 5'd3, 5'd2, 5'd0, 64'h0, 1'b0),
                    mkInstr(SUB, 5'd3, 5'd2, 5'd0, 64'h0, 1'b0),
                    mkInstr(SUB, 5'd3, 5'd2, 5'd0, 64'h0, 1'b0),
                    mkInstr(SUB, 5'd3, 5'd2, 5'd0, 64'h0, 1'b0));
   endtask

   scoreboard_entry_t nop, retI, callI, mRet, mCall, plain;
   fu_op opList[4];

   initial begin
      opList = '{ADD, SUB, JAL, JALR};
      nop   = mkInstr(SUB,  5'd3, 5'd2, 5'd0, 64'h100, 1'b0);
      retI  = mkInstr(JALR, 5'd0, 5'd1, 5'd0, 64'h200, 1'b0);
      callI = mkInstr(JAL,  5'd1, 5'd0, 5'd0, 64'h300, 1'b0);
      mRet  = mkInstr(ADD,  5'd0, 5'd0, 5'd1, 64'h400, 1'b0);
      mCall = mkInstr(ADD,  5'd0, 5'd0, 5'd2, 64'h500, 1'b0);
      plain = mkInstr(ADD,  5'd5, 5'd0, 5'd7, 64'h600, 1'b0);

      rstN = 1'b0; flush = 1'b0; csrEn = 1'b1; enforce = 1'b1;
      commitBus.commit_ack = '0;
      for (int k = 0; k < NP; k++) commitBus.commit_instr[k] = nop;
      modelReset();
      #2;
      checkOutput("rstExcValid", {63'd0, excOut.valid}, 64'd0);
      checkOutput("rstCount", {60'd0, violCount}, 64'd0);
      checkOutput("rstPending", {62'd0, pending}, 64'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;

      // return followed by its marker in the same cycle
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011, retI, mkInstr(ADD, 5'd0, 5'd0, 5'd1, 64'h204, 1'b0), nop, nop);
      checkOutput("retMarkerSameCycle", {60'd0, violCount}, 64'd0);

      // call in slot1, non-marker next cycle raises the breakpoint
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011, plain, mkInstr(JAL, 5'd1, 5'd0, 5'd0, 64'h8000_0010, 1'b0), nop, nop);
      checkOutput("callArmed", {62'd0, pending}, 64'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, mkInstr(ADD, 5'd0, 5'd0, 5'd5, 64'h8000_0014, 1'b0), nop, nop, nop);
      checkOutput("violValid", {63'd0, excOut.valid}, 64'd1);
      checkOutput("violTval", excOut.tval, 64'h8000_0014);
      checkOutput("violCause", excOut.cause, 64'd3);
      checkOutput("violCountOne", {60'd0, violCount}, 64'd1);
      idleCycle();
      checkOutput("violPulseEnds", {63'd0, excOut.valid}, 64'd0);

      // pending survives idle cycles
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, callI, nop, nop, nop);
      for (int i = 0; i < 3; i++) begin
         idleCycle();
         checkOutput("idlePending", {62'd0, pending}, 64'd2);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, mCall, nop, nop, nop);
      checkOutput("idleMarkerOk", {60'd0, violCount}, 64'd1);

      // two violations in one cycle, log-only
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, retI,
                    mkInstr(ADD, 5'd3, 5'd0, 5'd1, 64'h1004, 1'b0), callI,
                    mkInstr(SUB, 5'd0, 5'd0, 5'd2, 64'h100C, 1'b0));
      checkOutput("dualValid", {63'd0, excOut.valid}, 64'd0);
      checkOutput("dualCfi", {63'd0, cfiSig}, 64'd1);
      checkOutput("dualCount", {60'd0, violCount}, 64'd3);
      checkOutput("dualPc", lastPc, 64'h1004);

      // flush abandons a pending return check
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, retI, nop, nop, nop);
      applyStimulus(1'b1, 1'b1, 1'b1, 4'b0001, plain, nop, nop, nop);
      checkOutput("flushNoViol", {63'd0, cfiSig}, 64'd0);
      checkOutput("flushPending", {62'd0, pending}, 64'd0);

      // excepting slot drops the check; later slots start from none
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, callI, nop, nop, nop);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011, mkInstr(ADD, 5'd5, 5'd0, 5'd0, 64'h700, 1'b1), plain, nop, nop);
      checkOutput("exClears", {60'd0, violCount}, 64'd3);

      // disabled checker
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, callI, nop, nop, nop);
      applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001, plain, nop, nop, nop);
      checkOutput("disabledPending", {62'd0, pending}, 64'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, plain, nop, nop, nop);

      // randomised mix
      for (int i = 0; i < 40; i++) begin
         scoreboard_entry_t r[4];
         int nAck;
         logic [3:0] ackV;
         for (int k = 0; k < 4; k++) begin
            r[k] = mkInstr(opList[$urandom_range(0, 3)], 5'($urandom_range(0, 2)),
                           5'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                           64'h2000 + 64'(i * 16 + k * 4), ($urandom_range(0, 7) == 0));
         end
         nAck = $urandom_range(0, 4);
         ackV = 4'((1 << nAck) - 1);
         applyStimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 11) != 0),
                       1'($urandom_range(0, 1)), ackV, r[0], r[1], r[2], r[3]);
      end

      // saturate the 4-bit counter: two violations per cycle
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 4'b1111, callI, plain, callI, plain);
      end
      checkOutput("saturated", {60'd0, violCount}, 64'hF);

      // async reset mid-cycle while a return check is pending
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, retI, nop, nop, nop);
      commitBus.commit_ack = 4'b0001;
      commitBus.commit_instr[0] = plain;
      #3;
      rstN = 1'b0;
      #1;
      checkOutput("asyncExcValid", {63'd0, excOut.valid}, 64'd0);
      checkOutput("asyncCount", {60'd0, violCount}, 64'd0);
      checkOutput("asyncPc", lastPc, 64'd0);
      checkOutput("asyncPending", {62'd0, pending}, 64'd0);
      checkOutput("asyncCfi", {63'd0, cfiSig}, 64'd0);
      commitBus.commit_ack = '0;
      modelReset();
      @(posedge clk);
      #1;
      rstN = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0001, plain, nop, nop, nop);
      checkOutput("postResetNoViol", {60'd0, violCount}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
